// File: rtl/axi_sram_bank_slave.sv
// axi_sram_bank_slave: single-port AXI slave SRAM, one transaction at a time.
// Supports FIXED/INCR/WRAP bursts, byte strobes and alternating read/write
// priority when both address channels request in the same cycle.
// Optional build macro: AXI_SRAM_BANK_RANGE_CHECK_EN - addresses with bits
// above the memory span are suppressed (writes) or return zero (reads) and
// answer SLVERR; without it such addresses alias modulo the depth.
//
// state | meaning
// IDLE  | waiting for an AW or AR request, arbitrating between them
// WDATA | accepting write beats until len+1 have been taken
// WRESP | presenting the write response
// RADDR | memory word address applied, read data captured at the edge
// RDATA | presenting one read beat until rready

module axi_sram_bank_slave #(
  parameter int BW_ADDR    = 32,
  parameter int BW_DATA    = 32,
  parameter int BW_TID     = 4,
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                 clk,
  input  logic                 rstnn,
  input  logic                 rxawvalid,
  output logic                 rxawready,
  input  logic [BW_ADDR-1:0]   rxawaddr,
  input  logic [BW_TID-1:0]    rxawid,
  input  logic [7:0]           rxawlen,
  input  logic [2:0]           rxawsize,
  input  logic [1:0]           rxawburst,
  input  logic                 rxwvalid,
  output logic                 rxwready,
  input  logic [BW_TID-1:0]    rxwid,
  input  logic [BW_DATA-1:0]   rxwdata,
  input  logic [BW_DATA/8-1:0] rxwstrb,
  input  logic                 rxwlast,
  output logic                 rxbvalid,
  input  logic                 rxbready,
  output logic [BW_TID-1:0]    rxbid,
  output logic [1:0]           rxbresp,
  input  logic                 rxarvalid,
  output logic                 rxarready,
  input  logic [BW_ADDR-1:0]   rxaraddr,
  input  logic [BW_TID-1:0]    rxarid,
  input  logic [7:0]           rxarlen,
  input  logic [2:0]           rxarsize,
  input  logic [1:0]           rxarburst,
  output logic                 rxrvalid,
  input  logic                 rxrready,
  output logic [BW_TID-1:0]    rxrid,
  output logic [BW_DATA-1:0]   rxrdata,
  output logic                 rxrlast,
  output logic [1:0]           rxrresp
);

  localparam int BW_STRB   = BW_DATA / 8;
  localparam int OFF       = $clog2(BW_STRB);
  localparam int SPAN_BITS = DEPTH_LOG2 + OFF;
  localparam int DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [BW_ADDR-1:0] SPAN_MASK = {BW_ADDR{1'b1}} >> (BW_ADDR - SPAN_BITS);

  typedef enum logic [2:0] {IDLE, WDATA, WRESP, RADDR, RDATA} state_t;

  state_t state, state_nxt;

  logic [BW_DATA-1:0]    mem [0:DEPTH-1];
  logic [BW_ADDR-1:0]    addr_q, addr_nxt, addr_sum, incr, span_m1;
  logic [BW_TID-1:0]     id_q;
  logic [7:0]            len_q, beat_q;
  logic [2:0]            size_q, eff_size;
  logic [1:0]            burst_q;
  logic                  prio_w;
  logic                  err_q;
  logic [BW_DATA-1:0]    rdata_q;
  logic                  rlast_q;
  logic [1:0]            rresp_q;
  logic                  aw_grant, ar_grant, w_fire, r_fire, wrap_ok, oor;
  logic [DEPTH_LOG2-1:0] widx;
  logic                  unused_ok;

  // wid and wlast carry no information for a single-transaction slave
  assign unused_ok = ^{rxwid, rxwlast};

  assign aw_grant = rstnn && (state == IDLE) && rxawvalid && (!rxarvalid || prio_w);
  assign ar_grant = rstnn && (state == IDLE) && rxarvalid && (!rxawvalid || !prio_w);
  assign w_fire   = (state == WDATA) && rxwvalid;
  assign r_fire   = (state == RDATA) && rxrready;

  assign widx = addr_q[SPAN_BITS-1:OFF];

`ifdef AXI_SRAM_BANK_RANGE_CHECK_EN
  assign oor = |(addr_q & ~SPAN_MASK);
`else
  assign oor = 1'b0;
`endif

  // beat address generation; sizes wider than the bus are clamped to the bus
  always_comb begin
    eff_size = (size_q > 3'(OFF)) ? 3'(OFF) : size_q;
    incr     = BW_ADDR'(1) << eff_size;
    addr_sum = addr_q + incr;
    span_m1  = ((BW_ADDR'(len_q) + BW_ADDR'(1)) << eff_size) - BW_ADDR'(1);
    wrap_ok  = (burst_q == 2'b10) &&
               (len_q == 8'd1 || len_q == 8'd3 || len_q == 8'd7 || len_q == 8'd15);
    addr_nxt = addr_q;
    if (burst_q == 2'b00)
      addr_nxt = addr_q;
    else if (wrap_ok)
      addr_nxt = (addr_q & ~span_m1) | (addr_sum & span_m1);
    else
      // INCR (and reserved type 11): wrap within the memory span, keep upper bits
      addr_nxt = (addr_q & ~SPAN_MASK) | (addr_sum & SPAN_MASK);
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rstnn) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    rxawready = 1'b0;
    rxarready = 1'b0;
    rxwready  = 1'b0;
    rxbvalid  = 1'b0;
    rxrvalid  = 1'b0;
    case (state)
      IDLE: begin
        rxawready = aw_grant;
        rxarready = ar_grant;
        if (aw_grant)      state_nxt = WDATA;
        else if (ar_grant) state_nxt = RADDR;
      end
      WDATA: begin
        rxwready = 1'b1;
        if (w_fire && beat_q == len_q) state_nxt = WRESP;
      end
      WRESP: begin
        rxbvalid = 1'b1;
        if (rxbready) state_nxt = IDLE;
      end
      RADDR: state_nxt = RDATA;
      RDATA: begin
        rxrvalid = 1'b1;
        if (rxrready) state_nxt = rlast_q ? IDLE : RADDR;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // transaction context, beat tracking and registered read beat
  always_ff @(posedge clk) begin
    if (!rstnn) begin
      addr_q  <= '0;
      id_q    <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      beat_q  <= '0;
      prio_w  <= 1'b1;
      err_q   <= 1'b0;
      rdata_q <= '0;
      rlast_q <= 1'b0;
      rresp_q <= '0;
    end else begin
      if (aw_grant || ar_grant) begin
        addr_q  <= aw_grant ? rxawaddr  : rxaraddr;
        id_q    <= aw_grant ? rxawid    : rxarid;
        len_q   <= aw_grant ? rxawlen   : rxarlen;
        size_q  <= aw_grant ? rxawsize  : rxarsize;
        burst_q <= aw_grant ? rxawburst : rxarburst;
        beat_q  <= '0;
        prio_w  <= ~prio_w;
        err_q   <= 1'b0;
      end
      if (w_fire) begin
        beat_q <= beat_q + 8'd1;
        addr_q <= addr_nxt;
        if (oor) err_q <= 1'b1;
      end
      if (state == RADDR) begin
        rdata_q <= oor ? '0 : mem[widx];
        rlast_q <= (beat_q == len_q);
        rresp_q <= oor ? 2'b10 : 2'b00;
      end
      if (r_fire && !rlast_q) begin
        beat_q <= beat_q + 8'd1;
        addr_q <= addr_nxt;
      end
    end
  end

  // byte-lane write port; contents survive reset
  always_ff @(posedge clk) begin
    if (rstnn && w_fire && !oor) begin
      for (int i = 0; i < BW_STRB; i++)
        if (rxwstrb[i]) mem[widx][8*i +: 8] <= rxwdata[8*i +: 8];
    end
  end

  assign rxbid   = id_q;
  assign rxbresp = err_q ? 2'b10 : 2'b00;
  assign rxrid   = id_q;
  assign rxrdata = rdata_q;
  assign rxrlast = rlast_q;
  assign rxrresp = rresp_q;

endmodule

// File: doc/axi_sram_bank_slave.md
Name: axi_sram_bank_slave

Overview:
- Parametrised single-port AXI slave SRAM; next generation of the platform's fixed 32-bit system SRAM.
- Generalised data width, depth and transaction-ID width.
- Adds FIXED/INCR/WRAP burst support, narrow transfers, and fair read/write arbitration.
- Instantiated at platform top level behind the NoC slave port, clocked by the system SRAM clock.

Parameters:
- BW_ADDR, 32, AXI address width.
- BW_DATA, 32, data width in bits; legal values 32, 64, 128.
- BW_TID, 4, transaction ID width; set to REQUIRED_BW_OF_SLAVE_TID at instantiation.
- DEPTH_LOG2, 12, log2 of the number of BW_DATA-wide words.

Ports:
- clk  in  1  sole clock.
- rstnn  in  1  synchronous active-low reset.
- rxawvalid/rxawready  in/out  1  write address handshake.
- rxawaddr  in  BW_ADDR  write byte address.
- rxawid  in  BW_TID  write ID.
- rxawlen  in  8  write beats minus 1.
- rxawsize  in  3  log2 bytes per beat.
- rxawburst  in  2  00 FIXED, 01 INCR, 10 WRAP.
- rxwvalid/rxwready  in/out  1  write data handshake.
- rxwid  in  BW_TID  ignored.
- rxwdata  in  BW_DATA  write data.
- rxwstrb  in  BW_DATA/8  byte strobes.
- rxwlast  in  1  last write beat.
- rxbvalid/rxbready  out/in  1  write response handshake.
- rxbid  out  BW_TID  write response ID.
- rxbresp  out  2  write response.
- rxarvalid/rxarready  in/out  1  read address handshake.
- rxaraddr  in  BW_ADDR  read byte address.
- rxarid  in  BW_TID  read ID.
- rxarlen  in  8  read beats minus 1.
- rxarsize  in  3  log2 bytes per beat.
- rxarburst  in  2  read burst type.
- rxrvalid/rxrready  out/in  1  read data handshake.
- rxrid  out  BW_TID  read data ID.
- rxrdata  out  BW_DATA  read data.
- rxrlast  out  1  last read beat.
- rxrresp  out  2  read response.

Behaviour:
- Reset (rstnn=0 at a clk edge): state IDLE.
  - All ready/valid outputs 0; rxbid/rxrid/rxrdata/rxbresp/rxrresp/rxrlast = 0; priority pointer = write.
  - Memory contents are not reset.
  - Reset mid-burst aborts the transaction with no response.
- One transaction at a time; no outstanding queue.
- FSM states: IDLE, WDATA, WRESP, RADDR, RDATA.
- IDLE:
  - Only awvalid pending → awready=1. Only arvalid pending → arready=1.
  - Both pending → grant the side named by the priority pointer. The pointer flips after every grant, giving strict alternation.
  - Address handshake latches addr/id/len/size/burst and clears the beat counter.
  - Write grant → WDATA. Read grant → RADDR.
- WDATA:
  - wready=1.
  - Each beat: write the memory word at the current address; byte lanes gated by wstrb; advance the address.
  - After beat len+1 is accepted → WRESP. rxwlast is not used for termination; a wlast mismatch is tolerated.
- WRESP: bvalid=1, bid = latched awid, bresp=00. On bready → IDLE.
- RADDR: present the word address to memory (1-cycle read latency) → RDATA.
- RDATA:
  - rvalid=1; rdata/rid/rlast/rresp held stable while rready=0.
  - rlast=1 on beat len+1.
  - On rready: if last → IDLE, else advance the address → RADDR.
  - Throughput is one beat per 2 cycles.
- Address arithmetic:
  - Word index = addr[DEPTH_LOG2+log2(BW_DATA/8)-1 : log2(BW_DATA/8)]. Upper bits alias modulo depth.
  - Increment = 1<<size bytes. A size larger than the bus width is treated as the bus width.
  - FIXED: address constant.
  - INCR: address += increment; crossing the top of memory wraps to word 0.
  - WRAP: wrap boundary = (len+1)<<size bytes, aligned down. The address wraps to the boundary start when it reaches boundary+span. len values other than 1, 3, 7, 15 are treated as INCR.
  - Burst type 11 is treated as INCR.
- Narrow reads return the full word; the master selects lanes. Narrow writes rely on wstrb.
- Latency, single-beat read: AR handshake at cycle N → rvalid at N+2.
- Latency, single-beat write: W handshake at N → bvalid at N+1.

Optional Feature:
- Macro: AXI_SRAM_BANK_RANGE_CHECK_EN.
- Defined:
  - An address with any bit set above the memory span is out of range.
  - Out-of-range write beats are suppressed, and bresp=10 (SLVERR) if any beat was out of range.
  - Out-of-range read beats return rdata=0 with rresp=10 on that beat.
  - In-range beats behave normally.
- Undefined: addresses alias modulo depth; resp always 00.

Test Plan:
- Single write then read, BW_DATA=32: AW addr 0x10, data 0xDEADBEEF, strb 1111 → bresp 00; AR 0x10 → rdata 0xDEADBEEF, rlast=1, rvalid 2 cycles after AR handshake.
- INCR len=3 write at 0x100 (data 1,2,3,4), then WRAP len=3 size=2 read at 0x108 → rdata sequence 3,4,1,2, rlast on the 4th beat only.
- Strobe/narrow: write 0xFFFFFFFF to 0x20, then write 0x00000000 with strb 0100 → read returns 0xFF00FFFF.
- Simultaneous awvalid and arvalid held 4 consecutive times after reset → grants alternate W,R,W,R; bid/rid match the respective request IDs (e.g. 3 and 5).
- Backpressure: read len=1 with rready low for 5 cycles on beat 0 → rdata/rlast stable; total of exactly 2 beats delivered.
- With AXI_SRAM_BANK_RANGE_CHECK_EN, DEPTH_LOG2=4, BW_DATA=32: write to 0x40 → bresp 10, word 0 unchanged. Without the macro, the same write lands in word 0 with bresp 00.
